// File: rtl/paint_scanner.sv
// Frame scan driver: emits paint_x/paint_y, realigns paint_color, and streams pixels out of a small FIFO.
// Latency: a frame_start sampled at edge k presents (0,0) in cycle k+1; pix_valid rises in cycle k+2+LATENCY.
// Backpressure: painters cannot stall, so coordinates are only issued while a FIFO slot is reserved for the result.
module paint_scanner #(
  parameter int PAINT_W    = 480,
  parameter int PAINT_H    = 800,
  parameter int LATENCY    = 5,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               frame_start,
  output logic               busy,
  output logic               frame_done,
  output logic signed [15:0] paint_x,
  output logic signed [15:0] paint_y,
  input  logic        [15:0] paint_color,
  output logic        [15:0] pix_data,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic               pix_last
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW   = AW + 2;
  localparam int IW   = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state_q, state_d;

  // Coordinate counters (unsigned internally)
  logic [15:0] x_q, y_q;

  // Tag pipeline that tracks which painter results belong to issued coordinates
  logic [LATENCY-1:0] tag_vld;
  logic [LATENCY-1:0] tag_last;

  // Tags still in stages 0..LATENCY-2; the tag in the final stage is counted as push_pending
  logic [IW-1:0] in_flight;

  // Color FIFO
  logic [15:0]           mem_dat [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_last;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CNTW-1:0]       fifo_count;

  logic          at_last;
  logic          issue;
  logic          push;
  logic          pop;
  logic          push_pending;
  logic          go_idle;
  logic [CW-1:0] credit_used;

  assign paint_x   = $signed(x_q);
  assign paint_y   = $signed(y_q);
  assign busy      = (state_q != IDLE);
  assign pix_valid = (fifo_count != '0);
  assign pix_data  = mem_dat[rd_ptr];
  assign pix_last  = pix_valid && mem_last[rd_ptr];

  // Issue/credit decision and FIFO handshake strobes
  always_comb begin
    at_last      = (x_q == 16'(PAINT_W - 1)) && (y_q == 16'(PAINT_H - 1));
    push_pending = tag_vld[LATENCY-1];
    credit_used  = CW'(in_flight) + CW'(fifo_count) + CW'(push_pending);
    issue        = (state_q == RUN) && (credit_used < CW'(FIFO_DEPTH));
    push         = tag_vld[LATENCY-1];
    pop          = pix_valid && pix_ready;
    go_idle      = (state_q == DRAIN) && pop && pix_last;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_start) state_d = RUN;
      RUN:     if (issue && at_last) state_d = DRAIN;
      DRAIN:   if (go_idle) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and end-of-frame pulse
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_done <= go_idle;
    end
  end

  // Raster counters: advance on issue, hold on the final pixel, rewind when the frame completes
  always_ff @(posedge clk) begin
    if (!rstn || go_idle) begin
      x_q <= '0;
      y_q <= '0;
    end else if (issue && !at_last) begin
      if (x_q == 16'(PAINT_W - 1)) begin
        x_q <= '0;
        y_q <= y_q + 16'd1;
      end else begin
        x_q <= x_q + 16'd1;
      end
    end
  end

  // Tag shift register and in-flight counter; non-issue cycles shift in a zero tag
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tag_vld   <= '0;
      tag_last  <= '0;
      in_flight <= '0;
    end else begin
      tag_vld[0]  <= issue;
      tag_last[0] <= issue && at_last;
      for (int i = 1; i < LATENCY; i++) begin
        tag_vld[i]  <= tag_vld[i-1];
        tag_last[i] <= tag_last[i-1];
      end
      in_flight <= in_flight + IW'(issue) - IW'(tag_vld[LATENCY-2]);
    end
  end

  // FIFO storage and pointers; credits guarantee a free slot whenever push is high
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_dat[i] <= '0;
      mem_last   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        mem_dat[wr_ptr]  <= paint_color;
        mem_last[wr_ptr] <= tag_last[LATENCY-1];
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= fifo_count + CNTW'(push) - CNTW'(pop);
    end
  end

endmodule

// File: tb/tb_paint_scanner.sv
// Bench for paint_scanner on a 4x3 frame with a 5-cycle stub painter returning {y[7:0], x[7:0]}.
module tb_paint_scanner;

  localparam int W = 4, H = 3, LAT = 5, DEPTH = 8, NPIX = W * H;

  logic clk = 1'b0, rstn = 1'b0, frame_start = 1'b0, pix_ready = 1'b0;
  logic busy, frame_done, pix_valid, pix_last;
  logic signed [15:0] paint_x, paint_y;
  logic [15:0] paint_color, pix_data;

  int n_cmp = 0, n_bad = 0;
  int exp_idx = 0, n_pix = 0, n_done = 0;
  logic prev_stall = 1'b0;
  logic [15:0] prev_dat = '0;

  always #5 clk = ~clk;

  paint_scanner #(.PAINT_W(W), .PAINT_H(H), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .frame_start(frame_start), .busy(busy), .frame_done(frame_done),
    .paint_x(paint_x), .paint_y(paint_y), .paint_color(paint_color), .pix_data(pix_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_last(pix_last)
  );

  // stub painter: coordinate-derived color, LAT cycles behind
  logic [15:0] dly [LAT];
  always @(posedge clk) begin
    dly[0] <= {paint_y[7:0], paint_x[7:0]};
    for (int i = 1; i < LAT; i++) dly[i] <= dly[i-1];
  end
  assign paint_color = dly[LAT-1];

  function automatic logic [15:0] pix_of(input int i);
    return {8'(i / W), 8'(i % W)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // one cycle: drive inputs at the falling edge, then score the outputs held for this cycle
  task automatic tick(input logic start, input logic rdy, input logic rn);
    @(negedge clk);
    frame_start = start;
    pix_ready   = rdy;
    rstn        = rn;
    if (rn) begin
      if (prev_stall) begin
        chk("stall_valid", 32'(pix_valid), 32'd1);
        chk("stall_data", 32'(pix_data), 32'(prev_dat));
      end
      if (pix_valid && pix_ready) begin
        chk("pix_data", 32'(pix_data), 32'(pix_of(exp_idx)));
        chk("pix_last", 32'(pix_last), 32'(exp_idx == NPIX - 1));
        exp_idx = (exp_idx + 1) % NPIX;
        n_pix++;
      end
      if (frame_done) n_done++;
      prev_stall = pix_valid && !pix_ready;
      prev_dat   = pix_data;
    end else begin
      prev_stall = 1'b0;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_valid"}, 32'(pix_valid), 32'd0);
    chk({tag, "_last"}, 32'(pix_last), 32'd0);
    chk({tag, "_data"}, 32'(pix_data), 32'd0);
    chk({tag, "_x"}, 32'(paint_x), 32'd0);
    chk({tag, "_y"}, 32'(paint_y), 32'd0);
  endtask

  // mode 0: ready high; 1: 20-cycle stall after pixel 2; 2: random ready; 3: random ready + start pulses while busy
  task automatic run_frame(input int mode);
    int p0, d0, cyc, stall_left, done_cyc;
    logic r, s;
    bit stalled;
    p0 = n_pix; d0 = n_done; stall_left = 0; stalled = 0; done_cyc = 0;
    tick(1'b1, 1'b1, 1'b1);
    cyc = 0;
    while (n_done == d0 && cyc < 400) begin
      cyc++;
      r = 1'b1; s = 1'b0;
      if (mode == 1 && !stalled && n_pix - p0 == 3) begin
        stalled = 1; stall_left = 20;
      end
      if (stall_left > 0) r = 1'b0;
      if (mode == 2 || mode == 3) r = 1'($urandom_range(0, 1));
      if (mode == 3 && (cyc == 6 || n_pix - p0 == 11)) s = 1'b1;
      tick(s, r, 1'b1);
      if (stall_left == 10 || stall_left == 1) begin
        chk("frozen_x", 32'(paint_x), 32'd3);
        chk("frozen_y", 32'(paint_y), 32'd2);
        chk("stall_head", 32'(pix_data), 32'h0003);
        chk("stall_head_valid", 32'(pix_valid), 32'd1);
      end
      if (stall_left > 0) stall_left--;
      if (n_done != d0) done_cyc = cyc;
    end
    chk("frame_pixels", 32'(n_pix - p0), 32'(NPIX));
    chk("frame_done_seen", 32'(n_done - d0), 32'd1);
    if (mode == 0) chk("frame_done_cycle", 32'(done_cyc), 32'(2 + LAT + NPIX));
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("single_done", 32'(n_done - d0), 32'd1);
  endtask

  typedef struct {
    logic        start;
    logic        rdy;
    logic        vld;
    logic [15:0] dat;
    logic        last;
    logic        bsy;
    logic        done;
    logic [15:0] x;
    logic [15:0] y;
  } vec_t;

  vec_t tab[20];

  initial begin
    int p0, d0, cyc, p;

    // per-cycle expectations for cycles k+1..k+20 of a full-speed frame; extra starts at k+4 (RUN) and k+15 (DRAIN)
    for (int j = 1; j <= 20; j++) begin
      tab[j-1].start = (j == 4 || j == 15);
      tab[j-1].rdy   = 1'b1;
      tab[j-1].vld   = (j >= 7 && j <= 18);
      tab[j-1].dat   = (j >= 7 && j <= 18) ? pix_of(j - 7) : 16'h0;
      tab[j-1].last  = (j == 18);
      tab[j-1].bsy   = (j <= 18);
      tab[j-1].done  = (j == 19);
      p = (j <= 12) ? j - 1 : NPIX - 1;
      tab[j-1].x     = (j >= 19) ? 16'd0 : 16'(p % W);
      tab[j-1].y     = (j >= 19) ? 16'd0 : 16'(p / W);
    end

    // reset with random inputs
    for (int i = 0; i < 3; i++) begin
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      if (i > 0) chk_reset_outputs("reset");
    end
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
    chk_reset_outputs("post_reset");

    // table-driven full-speed frame
    tick(1'b1, 1'b1, 1'b1);
    for (int j = 0; j < 20; j++) begin
      tick(tab[j].start, tab[j].rdy, 1'b1);
      chk("tab_valid", 32'(pix_valid), 32'(tab[j].vld));
      if (tab[j].vld) begin
        chk("tab_data", 32'(pix_data), 32'(tab[j].dat));
        chk("tab_last", 32'(pix_last), 32'(tab[j].last));
      end
      chk("tab_busy", 32'(busy), 32'(tab[j].bsy));
      chk("tab_done", 32'(frame_done), 32'(tab[j].done));
      chk("tab_x", 32'(paint_x), 32'(tab[j].x));
      chk("tab_y", 32'(paint_y), 32'(tab[j].y));
    end

    run_frame(1);
    run_frame(3);
    run_frame(0);

    // mid-frame reset after 5 accepted pixels
    p0 = n_pix; d0 = n_done;
    tick(1'b1, 1'b1, 1'b1);
    cyc = 0;
    while (n_pix - p0 < 5 && cyc < 100) begin
      cyc++;
      tick(1'b0, 1'b1, 1'b1);
    end
    chk("abort_point", 32'(n_pix - p0), 32'd5);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    chk_reset_outputs("midreset");
    exp_idx = 0;
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
    chk("abort_no_done", 32'(n_done - d0), 32'd0);
    chk("abort_no_valid", 32'(pix_valid), 32'd0);
    run_frame(0);

    for (int f = 0; f < 4; f++) run_frame(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
